// File: rtl/piece_dropper.sv
// Drops a piece into the lowest empty row of a column, then hands the landed cell to the
// victory checker. Optional DRAW_DETECT_EN adds a placed-piece counter and a sticky draw flag.
module piece_dropper #(
  parameter int ROWS = 8,
  parameter int COLS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       move_valid,
  output logic       move_ready,
  input  logic [2:0] req_col,
  input  logic [1:0] req_player,
  output logic [2:0] row_read,
  output logic [2:0] col_read,
  input  logic [1:0] data_in,
  output logic       wr_en,
  output logic [2:0] wr_row,
  output logic [2:0] wr_col,
  output logic [1:0] wr_data,
  output logic       check_start,
  output logic [2:0] move_row,
  output logic [2:0] move_col,
  input  logic       check_done,
  input  logic [1:0] winner_in,
  output logic       drop_done,
  output logic [1:0] drop_status,
  output logic [1:0] game_winner,
  output logic       draw
);

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_WRITE, S_CHECK, S_WAIT, S_DONE
  } state_e;

  typedef enum logic [1:0] {
    ST_PLACED  = 2'b00,
    ST_FULL    = 2'b01,
    ST_ILLEGAL = 2'b10,
    ST_OVER    = 2'b11
  } status_e;

  localparam logic [3:0] COLS_W   = 4'(COLS);
  localparam logic [2:0] LAST_ROW = 3'(ROWS - 1);

  state_e     state_q, state_d;
  status_e    drop_status_q, drop_status_d;
  logic [2:0] col_q, col_d;
  logic [1:0] player_q, player_d;
  logic [2:0] row_idx_q, row_idx_d;
  logic [1:0] game_winner_q, game_winner_d;
  logic [2:0] move_row_q, move_row_d;
  logic [2:0] move_col_q, move_col_d;
  logic       move_ready_q, move_ready_d;
  logic [2:0] row_read_q, row_read_d;
  logic [2:0] col_read_q, col_read_d;
  logic       wr_en_q, wr_en_d;
  logic [2:0] wr_row_q, wr_row_d;
  logic [2:0] wr_col_q, wr_col_d;
  logic [1:0] wr_data_q, wr_data_d;
  logic       check_start_q, check_start_d;
  logic       drop_done_q, drop_done_d;
  logic       game_over;

`ifdef DRAW_DETECT_EN
  localparam logic [6:0] CELLS = 7'(ROWS * COLS);
  logic [6:0] placed_q, placed_d;
  logic       draw_q, draw_d;
`endif

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    state_d       = state_q;
    drop_status_d = drop_status_q;
    col_d         = col_q;
    player_d      = player_q;
    row_idx_d     = row_idx_q;
    game_winner_d = game_winner_q;
    move_row_d    = move_row_q;
    move_col_d    = move_col_q;
`ifdef DRAW_DETECT_EN
    placed_d      = placed_q;
    draw_d        = draw_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (move_valid && move_ready_q) begin
          col_d     = req_col;
          player_d  = req_player;
          row_idx_d = 3'd0;
          if (({1'b0, req_col} >= COLS_W) || (req_player == 2'b00) || (req_player == 2'b11)) begin
            drop_status_d = ST_ILLEGAL;
            state_d       = S_DONE;
          end else begin
            state_d = S_SCAN;
          end
        end
      end
      S_SCAN: begin
        if (data_in == 2'b00) begin
          state_d    = S_WRITE;
          move_row_d = row_idx_q;
          move_col_d = col_q;
`ifdef DRAW_DETECT_EN
          placed_d   = placed_q + 7'd1;
`endif
        end else if (row_idx_q == LAST_ROW) begin
          drop_status_d = ST_FULL;
          state_d       = S_DONE;
        end else begin
          row_idx_d = row_idx_q + 3'd1;
        end
      end
      S_WRITE: state_d = S_CHECK;
      S_CHECK: state_d = S_WAIT;
      S_WAIT: begin
        if (check_done) begin
          drop_status_d = ST_PLACED;
          if (winner_in != 2'b00) game_winner_d = winner_in;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
`ifdef DRAW_DETECT_EN
        if ((placed_q == CELLS) && (game_winner_q == 2'b00)) draw_d = 1'b1;
`endif
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they leave the flops aligned with it.
    wr_en_d       = (state_d == S_WRITE);
    wr_row_d      = wr_en_d ? row_idx_d : 3'd0;
    wr_col_d      = wr_en_d ? col_d : 3'd0;
    wr_data_d     = wr_en_d ? player_d : 2'b00;
    check_start_d = (state_d == S_CHECK);
    drop_done_d   = (state_d == S_DONE);
    row_read_d    = (state_d == S_SCAN) ? row_idx_d : 3'd0;
    col_read_d    = (state_d == S_SCAN) ? col_d : 3'd0;

`ifdef DRAW_DETECT_EN
    game_over = (game_winner_d != 2'b00) || draw_d;
`else
    game_over = (game_winner_d != 2'b00);
`endif
    move_ready_d = (state_d == S_IDLE) && !game_over;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      drop_status_q <= ST_PLACED;
      col_q         <= 3'd0;
      player_q      <= 2'b00;
      row_idx_q     <= 3'd0;
      game_winner_q <= 2'b00;
      move_row_q    <= 3'd0;
      move_col_q    <= 3'd0;
      move_ready_q  <= 1'b1;
      row_read_q    <= 3'd0;
      col_read_q    <= 3'd0;
      wr_en_q       <= 1'b0;
      wr_row_q      <= 3'd0;
      wr_col_q      <= 3'd0;
      wr_data_q     <= 2'b00;
      check_start_q <= 1'b0;
      drop_done_q   <= 1'b0;
`ifdef DRAW_DETECT_EN
      placed_q      <= 7'd0;
      draw_q        <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      drop_status_q <= drop_status_d;
      col_q         <= col_d;
      player_q      <= player_d;
      row_idx_q     <= row_idx_d;
      game_winner_q <= game_winner_d;
      move_row_q    <= move_row_d;
      move_col_q    <= move_col_d;
      move_ready_q  <= move_ready_d;
      row_read_q    <= row_read_d;
      col_read_q    <= col_read_d;
      wr_en_q       <= wr_en_d;
      wr_row_q      <= wr_row_d;
      wr_col_q      <= wr_col_d;
      wr_data_q     <= wr_data_d;
      check_start_q <= check_start_d;
      drop_done_q   <= drop_done_d;
`ifdef DRAW_DETECT_EN
      placed_q      <= placed_d;
      draw_q        <= draw_d;
`endif
    end
  end

  assign move_ready  = move_ready_q;
  assign row_read    = row_read_q;
  assign col_read    = col_read_q;
  assign wr_en       = wr_en_q;
  assign wr_row      = wr_row_q;
  assign wr_col      = wr_col_q;
  assign wr_data     = wr_data_q;
  assign check_start = check_start_q;
  assign move_row    = move_row_q;
  assign move_col    = move_col_q;
  assign drop_done   = drop_done_q;
  assign drop_status = drop_status_q;
  assign game_winner = game_winner_q;
`ifdef DRAW_DETECT_EN
  assign draw = draw_q;
`else
  assign draw = 1'b0;
`endif

endmodule

// File: tb/tb_piece_dropper.sv
// Bench for piece_dropper: bench-side board memory and victory checker, a transaction-level
// model of column heights and timing, and a per-cycle compare process.
module tb_piece_dropper;

`ifdef DRAW_DETECT_EN
  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam bit DRAW_EN = 1'b1;
`else
  localparam int ROWS = 8;
  localparam int COLS = 7;
  localparam bit DRAW_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       move_valid = 1'b0;
  logic       move_ready;
  logic [2:0] req_col = 3'd0;
  logic [1:0] req_player = 2'b00;
  logic [2:0] row_read, col_read;
  logic [1:0] data_in;
  logic       wr_en;
  logic [2:0] wr_row, wr_col;
  logic [1:0] wr_data;
  logic       check_start;
  logic [2:0] move_row, move_col;
  logic       check_done = 1'b0;
  logic [1:0] winner_in = 2'b00;
  logic       drop_done;
  logic [1:0] drop_status;
  logic [1:0] game_winner;
  logic       draw;

  piece_dropper #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk(clk), .rst_n(rst_n), .move_valid(move_valid), .move_ready(move_ready),
    .req_col(req_col), .req_player(req_player), .row_read(row_read), .col_read(col_read),
    .data_in(data_in), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
    .check_start(check_start), .move_row(move_row), .move_col(move_col),
    .check_done(check_done), .winner_in(winner_in), .drop_done(drop_done),
    .drop_status(drop_status), .game_winner(game_winner), .draw(draw)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Board memory seen by the dropper.
  logic [1:0] board [8][8];
  bit clr_board = 1'b0;
  assign data_in = board[row_read][col_read];
  always @(posedge clk) begin
    if (clr_board) begin
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++) board[r][c] <= 2'b00;
    end else if (wr_en) begin
      board[wr_row][wr_col] <= wr_data;
    end
  end

  // Victory checker stand-in: answers n cycles after check_start, otherwise emits stray pulses.
  int         bfm_cnt = 0;
  int         bfm_n = 1;
  logic [1:0] bfm_win = 2'b00;
  always @(negedge clk) begin
    check_done = 1'b0;
    winner_in  = 2'b00;
    if (bfm_cnt > 0) begin
      bfm_cnt--;
      if (bfm_cnt == 0) begin
        check_done = 1'b1;
        winner_in  = bfm_win;
      end
    end else if (check_start) begin
      bfm_cnt = bfm_n;
    end else if ($urandom_range(0, 7) == 0) begin
      check_done = 1'b1;
      winner_in  = 2'($urandom_range(1, 3));
    end
  end

  // Reference model: column heights plus the cycle plan of the current transaction.
  int         heights [COLS];
  int         placed = 0;
  logic [1:0] old_w = 2'b00, new_w = 2'b00;
  bit         old_draw = 1'b0, new_draw = 1'b0;
  int         tr_a = -100, tr_scan = 0, tr_wr = -100, tr_cs = -100, tr_done = -100, tr_row = 0;
  logic [2:0] tr_col = 3'd0;
  logic [1:0] tr_player = 2'b00, tr_status = 2'b00;
  bit         chk_en = 1'b0;

  always @(negedge clk) begin
    logic [1:0] exp_gw;
    bit         exp_dr, over, in_scan;
    if (chk_en) begin
      exp_gw  = (cyc >= tr_done) ? new_w : old_w;
      exp_dr  = (cyc > tr_done) ? new_draw : old_draw;
      over    = (exp_gw != 2'b00) || exp_dr;
      in_scan = (cyc > tr_a) && (cyc <= tr_a + tr_scan);
      check("move_ready", move_ready, 32'((cyc <= tr_a || cyc > tr_done) && !over));
      check("row_read", row_read, in_scan ? 32'(cyc - tr_a - 1) : 32'd0);
      check("col_read", col_read, in_scan ? 32'(tr_col) : 32'd0);
      check("wr_en", wr_en, 32'(cyc == tr_wr));
      if (cyc == tr_wr) begin
        check("wr_row", wr_row, tr_row);
        check("wr_col", wr_col, tr_col);
        check("wr_data", wr_data, tr_player);
      end
      check("check_start", check_start, 32'(cyc == tr_cs));
      check("drop_done", drop_done, 32'(cyc == tr_done));
      if (cyc == tr_done) check("drop_status", drop_status, tr_status);
      if (tr_wr >= 0 && cyc >= tr_wr && cyc <= tr_done) begin
        check("move_row", move_row, tr_row);
        check("move_col", move_col, tr_col);
      end
      check("game_winner", game_winner, exp_gw);
      check("draw", draw, exp_dr);
    end
  end

  // Observed DUT events, used by the hand-computed literal checks.
  int         mon_done_cyc = 0, mon_done_cnt = 0, mon_wr_cnt = 0, mon_cs_cnt = 0;
  logic [1:0] mon_status = 2'b00, mon_wr_data = 2'b00;
  logic [2:0] mon_wr_row = 3'd0, mon_wr_col = 3'd0, mon_move_row = 3'd0;
  int         last_a = 0;
  always @(negedge clk) begin
    if (drop_done) begin
      mon_done_cyc = cyc;
      mon_done_cnt++;
      mon_status   = drop_status;
      mon_move_row = move_row;
    end
    if (wr_en) begin
      mon_wr_cnt++;
      mon_wr_row  = wr_row;
      mon_wr_col  = wr_col;
      mon_wr_data = wr_data;
    end
    if (check_start) mon_cs_cnt++;
  end

  task automatic do_reset();
    chk_en = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    clr_board = 1'b1;
    @(negedge clk);
    check("rst_move_ready", move_ready, 1);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_row", wr_row, 0);
    check("rst_check_start", check_start, 0);
    check("rst_drop_done", drop_done, 0);
    check("rst_drop_status", drop_status, 0);
    check("rst_game_winner", game_winner, 0);
    check("rst_draw", draw, 0);
    check("rst_row_read", row_read, 0);
    check("rst_col_read", col_read, 0);
    check("rst_move_row", move_row, 0);
    check("rst_move_col", move_col, 0);
    #1 rst_n = 1'b1;
    clr_board = 1'b0;
    bfm_cnt = 0;
    for (int c = 0; c < COLS; c++) heights[c] = 0;
    placed = 0;
    old_w = 2'b00; new_w = 2'b00; old_draw = 1'b0; new_draw = 1'b0;
    tr_a = -100; tr_scan = 0; tr_wr = -100; tr_cs = -100; tr_done = -100;
    chk_en = 1'b1;
  endtask

  task automatic do_move(input int col, input int player, input int n, input logic [1:0] win,
                         input int abort_after);
    int a, k;
    @(negedge clk);
    #1;
    move_valid = 1'b1;
    req_col    = 3'(col);
    req_player = 2'(player);
    if ((new_w != 2'b00) || new_draw) begin
      repeat (3) @(negedge clk);
      #1 move_valid = 1'b0;
      #2;
      return;
    end
    a = cyc;
    last_a = a;
    old_w = new_w;
    old_draw = new_draw;
    tr_a = a; tr_col = 3'(col); tr_player = 2'(player);
    tr_wr = -100; tr_cs = -100; tr_row = 0;
    if (col >= COLS || player == 0 || player == 3) begin
      tr_scan = 0; tr_done = a + 1; tr_status = 2'b10;
    end else if (heights[col] == ROWS) begin
      tr_scan = ROWS; tr_done = a + ROWS + 1; tr_status = 2'b01;
    end else begin
      k = heights[col];
      tr_scan = k + 1; tr_row = k;
      tr_wr = a + k + 2; tr_cs = a + k + 3; tr_done = a + k + 4 + n;
      tr_status = 2'b00;
      heights[col]++;
      placed++;
      bfm_n = n;
      bfm_win = win;
      new_w = win;
      new_draw = DRAW_EN && (placed == ROWS * COLS) && (win == 2'b00);
    end
    @(negedge clk);
    #1 move_valid = 1'b0;
    req_col    = 3'($urandom);
    req_player = 2'($urandom);
    if (abort_after > 0) begin
      repeat (abort_after) @(negedge clk);
      do_reset();
      return;
    end
    while (cyc < tr_done) @(negedge clk);
    #2;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0, w0, c0, col, player;
    logic [1:0] win;
    do_reset();

    // Empty column: k=0, n=4 -> 1+1+1+4+1 = 8 cycles.
    do_move(3, 1, 4, 2'b00, 0);
    check("lat_empty", 32'(mon_done_cyc - last_a), 8);
    check("wr_row_empty", mon_wr_row, 0);
    check("wr_col_empty", mon_wr_col, 3);
    check("wr_data_empty", mon_wr_data, 1);
    check("status_empty", mon_status, 0);
    check("move_row_empty", mon_move_row, 0);

`ifndef DRAW_DETECT_EN
    for (int i = 0; i < 3; i++) do_move(5, (i % 2) + 1, 1, 2'b00, 0);
    // k=3, n=2 -> 4+1+1+2+1 = 9 cycles, lands on row 3.
    do_move(5, 2, 2, 2'b00, 0);
    check("lat_col5", 32'(mon_done_cyc - last_a), 9);
    check("wr_row_col5", mon_wr_row, 3);
    check("wr_col_col5", mon_wr_col, 5);
    check("wr_data_col5", mon_wr_data, 2);

    for (int i = 0; i < 8; i++) do_move(2, (i % 2) + 1, 1, 2'b00, 0);
    w0 = mon_wr_cnt; c0 = mon_cs_cnt;
    do_move(2, 1, 3, 2'b00, 0);
    check("lat_full", 32'(mon_done_cyc - last_a), 9);
    check("status_full", mon_status, 1);
    check("wr_count_full", 32'(mon_wr_cnt - w0), 0);
    check("cs_count_full", 32'(mon_cs_cnt - c0), 0);
`endif

    w0 = mon_wr_cnt;
    do_move(7, 1, 1, 2'b00, 0);
    check("lat_bad_col", 32'(mon_done_cyc - last_a), 1);
    check("status_bad_col", mon_status, 2);
    do_move(1, 3, 1, 2'b00, 0);
    check("status_bad_p3", mon_status, 2);
    do_move(1, 0, 1, 2'b00, 0);
    check("status_bad_p0", mon_status, 2);
    check("wr_count_illegal", 32'(mon_wr_cnt - w0), 0);

    for (int i = 0; i < 120; i++) begin
      if ((new_w != 2'b00) || new_draw) do_reset();
      col = $urandom_range(0, 7);
      player = ($urandom_range(0, 9) == 0) ? 3 * $urandom_range(0, 1) : $urandom_range(1, 2);
      win = ($urandom_range(0, 29) == 0) ? 2'($urandom_range(1, 2)) : 2'b00;
      do_move(col, player, $urandom_range(1, 6), win, 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Reset during WAIT: no completion afterwards.
    do_reset();
    d0 = mon_done_cnt; w0 = mon_wr_cnt;
    do_move(0, 1, 6, 2'b00, 5);
    repeat (10) @(negedge clk);
    check("no_done_after_reset", mon_done_cnt, d0);
    check("one_write_before_reset", 32'(mon_wr_cnt - w0), 1);

    do_move(0, 1, 3, 2'b01, 0);
    check("winner_latched", game_winner, 1);
    check("winner_status", mon_status, 0);
    @(negedge clk);
    check("ready_after_win", move_ready, 0);
    d0 = mon_done_cnt;
    do_move(1, 2, 1, 2'b00, 0);
    check("ignored_after_win", mon_done_cnt, d0);
    check("winner_sticky", game_winner, 1);
    do_reset();
    check("winner_cleared", game_winner, 0);
    check("ready_restored", move_ready, 1);

`ifdef DRAW_DETECT_EN
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        if (c == 3 && r == 3) check("no_draw_at_15", draw, 0);
        do_move(c, ((c + r) % 2) + 1, 1, 2'b00, 0);
      end
    @(negedge clk);
    check("draw_after_16", draw, 1);
    check("ready_after_draw", move_ready, 0);
`endif

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
